// File: rtl/stdp_update_sched.sv
// STDP weight-update scheduler: tracks pre/post spike timing per synapse,
// captures potentiation/depression requests into per-slot pending registers,
// and serialises them round-robin onto a single valid/ready update port.
module stdp_update_sched #(
   parameter int unsigned NUM_PRE = 5,
   parameter int unsigned TW      = 8,
   parameter int unsigned WINDOW  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_PRE-1:0] pre_spike,
   input  logic               post_spike,
   input  logic               upd_ready,
   output logic               upd_valid,
   output logic [2:0]         upd_idx,
   output logic [TW-1:0]      upd_dt,
   output logic               upd_ltp,
   output logic [NUM_PRE-1:0] pend,
   output logic [7:0]         drop_cnt
);

   localparam logic [TW:0] WIN_C  = (TW+1)'(WINDOW);
   localparam logic [2:0]  LAST_C = 3'(NUM_PRE - 1);

   // spike timers
   logic [TW-1:0]      pre_tmr_q [NUM_PRE];
   logic [TW-1:0]      pre_tmr_d [NUM_PRE];
   logic [TW-1:0]      post_tmr_q, post_tmr_d;

   // capture requests for this edge
   logic [NUM_PRE-1:0] cap;
   logic [NUM_PRE-1:0] cap_ltp;
   logic [TW-1:0]      cap_dt [NUM_PRE];

   // pending slots
   logic [NUM_PRE-1:0] pend_q, pend_d;
   logic [NUM_PRE-1:0] slot_ltp_q, slot_ltp_d;
   logic [TW-1:0]      slot_dt_q [NUM_PRE];
   logic [TW-1:0]      slot_dt_d [NUM_PRE];

   // arbiter
   logic [2:0]         rr_q, rr_d;
   logic               win_found;
   logic [2:0]         win_idx;
   logic [NUM_PRE-1:0] win_oh;
   logic [TW-1:0]      win_dt;
   logic               win_ltp;
   logic               load;

   // output register and drop counter
   logic               valid_q, valid_d;
   logic [2:0]         idx_q, idx_d;
   logic [TW-1:0]      dt_q, dt_d;
   logic               ltp_q, ltp_d;
   logic [7:0]         drop_q, drop_d;
   logic [3:0]         ndrop;
   logic [8:0]         drop_sum;

   // Timer next state: clear on spike, otherwise saturating increment
   always_comb begin
      for (int unsigned k = 0; k < NUM_PRE; k++) begin
         if (pre_spike[k])
            pre_tmr_d[k] = '0;
         else if (pre_tmr_q[k] == '1)
            pre_tmr_d[k] = pre_tmr_q[k];
         else
            pre_tmr_d[k] = pre_tmr_q[k] + TW'(1);
      end
      if (post_spike)
         post_tmr_d = '0;
      else if (post_tmr_q == '1)
         post_tmr_d = post_tmr_q;
      else
         post_tmr_d = post_tmr_q + TW'(1);
   end

   // Pairing detection against the registered (pre-edge) timer values
   always_comb begin
      for (int unsigned k = 0; k < NUM_PRE; k++) begin
         cap[k]     = 1'b0;
         cap_ltp[k] = 1'b0;
         cap_dt[k]  = '0;
         if (post_spike) begin
            if (pre_spike[k]) begin
               cap[k]     = 1'b1;
               cap_ltp[k] = 1'b1;
            end else if ({1'b0, pre_tmr_q[k]} < WIN_C) begin
               cap[k]     = 1'b1;
               cap_ltp[k] = 1'b1;
               cap_dt[k]  = pre_tmr_q[k] + TW'(1);
            end
         end else if (pre_spike[k] && ({1'b0, post_tmr_q} < WIN_C)) begin
            cap[k]    = 1'b1;
            cap_dt[k] = post_tmr_q + TW'(1);
         end
      end
   end

   // Round-robin pick: first pending slot at/after rr, then wrap to the lowest
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_oh    = '0;
      win_dt    = '0;
      win_ltp   = 1'b0;
      for (int unsigned k = 0; k < NUM_PRE; k++) begin
         if (!win_found && pend_q[k] && (k >= 32'(rr_q))) begin
            win_found = 1'b1;
            win_idx   = 3'(k);
            win_oh[k] = 1'b1;
            win_dt    = slot_dt_q[k];
            win_ltp   = slot_ltp_q[k];
         end
      end
      for (int unsigned k = 0; k < NUM_PRE; k++) begin
         if (!win_found && pend_q[k]) begin
            win_found = 1'b1;
            win_idx   = 3'(k);
            win_oh[k] = 1'b1;
            win_dt    = slot_dt_q[k];
            win_ltp   = slot_ltp_q[k];
         end
      end
   end

   // Output register loads when empty or transferring; rr follows the winner
   always_comb begin
      load    = win_found && (!valid_q || upd_ready);
      valid_d = valid_q;
      idx_d   = idx_q;
      dt_d    = dt_q;
      ltp_d   = ltp_q;
      rr_d    = rr_q;
      if (load) begin
         valid_d = 1'b1;
         idx_d   = win_idx;
         dt_d    = win_dt;
         ltp_d   = win_ltp;
         rr_d    = (win_idx == LAST_C) ? 3'd0 : win_idx + 3'd1;
      end else if (valid_q && upd_ready) begin
         valid_d = 1'b0;
      end
   end

   // Slot update: a capture into a slot leaving this edge is not a drop
   always_comb begin
      ndrop = '0;
      for (int unsigned k = 0; k < NUM_PRE; k++) begin
         pend_d[k]     = pend_q[k];
         slot_dt_d[k]  = slot_dt_q[k];
         slot_ltp_d[k] = slot_ltp_q[k];
         if (load && win_oh[k])
            pend_d[k] = 1'b0;
         if (cap[k]) begin
            pend_d[k]     = 1'b1;
            slot_dt_d[k]  = cap_dt[k];
            slot_ltp_d[k] = cap_ltp[k];
            if (pend_q[k] && !(load && win_oh[k]))
               ndrop = ndrop + 4'd1;
         end
      end
      drop_sum = {1'b0, drop_q} + {5'd0, ndrop};
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NUM_PRE; k++) begin
            pre_tmr_q[k] <= '1;
            slot_dt_q[k] <= '0;
         end
         post_tmr_q <= '1;
         pend_q     <= '0;
         slot_ltp_q <= '0;
         rr_q       <= '0;
         valid_q    <= 1'b0;
         idx_q      <= '0;
         dt_q       <= '0;
         ltp_q      <= 1'b0;
         drop_q     <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_PRE; k++) begin
            pre_tmr_q[k] <= pre_tmr_d[k];
            slot_dt_q[k] <= slot_dt_d[k];
         end
         post_tmr_q <= post_tmr_d;
         pend_q     <= pend_d;
         slot_ltp_q <= slot_ltp_d;
         rr_q       <= rr_d;
         valid_q    <= valid_d;
         idx_q      <= idx_d;
         dt_q       <= dt_d;
         ltp_q      <= ltp_d;
         drop_q     <= drop_d;
      end
   end

   assign upd_valid = valid_q;
   assign upd_idx   = idx_q;
   assign upd_dt    = dt_q;
   assign upd_ltp   = ltp_q;
   assign pend      = pend_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stdp_update_sched.sv
// Directed testbench for stdp_update_sched with hand-computed expectations.
module tb_stdp_update_sched;

   localparam int unsigned NUM_PRE = 5;
   localparam int unsigned TW      = 8;
   localparam int unsigned WINDOW  = 16;

   logic               clk;
   logic               rst_n;
   logic [NUM_PRE-1:0] pre_spike;
   logic               post_spike;
   logic               upd_ready;
   logic               upd_valid;
   logic [2:0]         upd_idx;
   logic [TW-1:0]      upd_dt;
   logic               upd_ltp;
   logic [NUM_PRE-1:0] pend;
   logic [7:0]         drop_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   stdp_update_sched #(
      .NUM_PRE(NUM_PRE),
      .TW     (TW),
      .WINDOW (WINDOW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pre_spike (pre_spike),
      .post_spike(post_spike),
      .upd_ready (upd_ready),
      .upd_valid (upd_valid),
      .upd_idx   (upd_idx),
      .upd_dt    (upd_dt),
      .upd_ltp   (upd_ltp),
      .pend      (pend),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one clock edge, then settle before sampling/driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      pre_spike  = '0;
      post_spike = 1'b0;
      upd_ready  = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // pre[3] at k, post at k+1..k+3 with upd_ready low
   task automatic overwrite_stim();
      do_reset();
      pre_spike = 5'b01000;
      step();
      pre_spike  = '0;
      post_spike = 1'b1;
      step();
      step();
      step();
      post_spike = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if ({upd_valid, upd_idx, upd_dt, upd_ltp, pend, drop_cnt} !== '0)
         $display("FAIL reset_state got v=%0b idx=%0d dt=%0d ltp=%0b pend=%b drop=%0d want all zero",
                  upd_valid, upd_idx, upd_dt, upd_ltp, pend, drop_cnt);
      else pass_cnt++;
   endtask

   task automatic test_post_only();
      do_reset();
      upd_ready  = 1'b1;
      post_spike = 1'b1;
      step();
      post_spike = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if ({upd_valid, pend} !== 6'b0)
            $display("FAIL post_only got v=%0b pend=%b want v=0 pend=00000", upd_valid, pend);
         else pass_cnt++;
         step();
      end
   endtask

   task automatic test_ltp();
      do_reset();
      upd_ready = 1'b1;
      pre_spike = 5'b00100;
      step();
      pre_spike = '0;
      step();
      step();
      post_spike = 1'b1;
      step();
      post_spike = 1'b0;
      total_cnt++;
      if ({upd_valid, pend} !== {1'b0, 5'b00100})
         $display("FAIL ltp_pend got v=%0b pend=%b want v=0 pend=00100", upd_valid, pend);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({upd_valid, upd_idx, upd_dt, upd_ltp, pend} !== {1'b1, 3'd2, 8'd3, 1'b1, 5'b00000})
         $display("FAIL ltp_out got v=%0b idx=%0d dt=%0d ltp=%0b pend=%b want 1/2/3/1/00000",
                  upd_valid, upd_idx, upd_dt, upd_ltp, pend);
      else pass_cnt++;
      step();
      total_cnt++;
      if (upd_valid !== 1'b0)
         $display("FAIL ltp_one_cycle got v=%0b want 0", upd_valid);
      else pass_cnt++;
   endtask

   task automatic test_ltd();
      do_reset();
      upd_ready  = 1'b1;
      post_spike = 1'b1;
      step();
      post_spike = 1'b0;
      repeat (4) step();
      pre_spike = 5'b00001;
      step();
      pre_spike = '0;
      total_cnt++;
      if (pend !== 5'b00001)
         $display("FAIL ltd_pend got pend=%b want 00001", pend);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({upd_valid, upd_idx, upd_dt, upd_ltp} !== {1'b1, 3'd0, 8'd5, 1'b0})
         $display("FAIL ltd_out got v=%0b idx=%0d dt=%0d ltp=%0b want 1/0/5/0",
                  upd_valid, upd_idx, upd_dt, upd_ltp);
      else pass_cnt++;
      // coincident pre and post
      do_reset();
      upd_ready  = 1'b1;
      pre_spike  = 5'b00010;
      post_spike = 1'b1;
      step();
      pre_spike  = '0;
      post_spike = 1'b0;
      step();
      total_cnt++;
      if ({upd_valid, upd_idx, upd_dt, upd_ltp} !== {1'b1, 3'd1, 8'd0, 1'b1})
         $display("FAIL coincident_out got v=%0b idx=%0d dt=%0d ltp=%0b want 1/1/0/1",
                  upd_valid, upd_idx, upd_dt, upd_ltp);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      upd_ready = 1'b0;
      pre_spike = 5'b11111;
      step();
      pre_spike = '0;
      step();
      post_spike = 1'b1;
      step();
      post_spike = 1'b0;
      total_cnt++;
      if (pend !== 5'b11111)
         $display("FAIL b2b_pend_all got pend=%b want 11111", pend);
      else pass_cnt++;
      step();
      total_cnt++;
      if (pend !== 5'b11110)
         $display("FAIL b2b_pend_after_load got pend=%b want 11110", pend);
      else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         total_cnt++;
         if ({upd_valid, upd_idx, upd_dt, upd_ltp} !== {1'b1, 3'd0, 8'd2, 1'b1})
            $display("FAIL b2b_hold cyc=%0d got v=%0b idx=%0d dt=%0d ltp=%0b want 1/0/2/1",
                     i, upd_valid, upd_idx, upd_dt, upd_ltp);
         else pass_cnt++;
         if (i < 9) step();
      end
      upd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         total_cnt++;
         if ({upd_valid, upd_idx, upd_dt} !== {1'b1, 3'(i), 8'd2})
            $display("FAIL b2b_stream n=%0d got v=%0b idx=%0d dt=%0d want 1/%0d/2",
                     i, upd_valid, upd_idx, upd_dt, i);
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if ({upd_valid, pend} !== 6'b0)
         $display("FAIL b2b_drain got v=%0b pend=%b want 0/00000", upd_valid, pend);
      else pass_cnt++;
   endtask

   task automatic test_window();
      // just outside the window: no pairing
      do_reset();
      upd_ready = 1'b1;
      pre_spike = 5'b10000;
      step();
      pre_spike = '0;
      repeat (WINDOW) step();
      post_spike = 1'b1;
      step();
      post_spike = 1'b0;
      total_cnt++;
      if (pend !== 5'b00000)
         $display("FAIL window_out_pend got pend=%b want 00000", pend);
      else pass_cnt++;
      step();
      total_cnt++;
      if (upd_valid !== 1'b0)
         $display("FAIL window_out_valid got v=%0b want 0", upd_valid);
      else pass_cnt++;
      // last cycle inside the window
      do_reset();
      upd_ready = 1'b1;
      pre_spike = 5'b10000;
      step();
      pre_spike = '0;
      repeat (WINDOW - 1) step();
      post_spike = 1'b1;
      step();
      post_spike = 1'b0;
      step();
      total_cnt++;
      if ({upd_valid, upd_idx, upd_dt, upd_ltp} !== {1'b1, 3'd4, 8'd16, 1'b1})
         $display("FAIL window_edge got v=%0b idx=%0d dt=%0d ltp=%0b want 1/4/16/1",
                  upd_valid, upd_idx, upd_dt, upd_ltp);
      else pass_cnt++;
   endtask

   task automatic test_overwrite();
      overwrite_stim();
      total_cnt++;
      if ({upd_valid, upd_idx, upd_dt, upd_ltp} !== {1'b1, 3'd3, 8'd1, 1'b1})
         $display("FAIL ovw_out got v=%0b idx=%0d dt=%0d ltp=%0b want 1/3/1/1",
                  upd_valid, upd_idx, upd_dt, upd_ltp);
      else pass_cnt++;
      total_cnt++;
      if ({pend, drop_cnt} !== {5'b01000, 8'd1})
         $display("FAIL ovw_pend_drop got pend=%b drop=%0d want 01000/1", pend, drop_cnt);
      else pass_cnt++;
      upd_ready = 1'b1;
      step();
      total_cnt++;
      if ({upd_valid, upd_idx, upd_dt, upd_ltp, pend} !== {1'b1, 3'd3, 8'd3, 1'b1, 5'b00000})
         $display("FAIL ovw_second got v=%0b idx=%0d dt=%0d ltp=%0b pend=%b want 1/3/3/1/00000",
                  upd_valid, upd_idx, upd_dt, upd_ltp, pend);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      overwrite_stim();
      total_cnt++;
      if ({upd_valid, pend, drop_cnt} !== {1'b1, 5'b01000, 8'd1})
         $display("FAIL rstmid_pre got v=%0b pend=%b drop=%0d want 1/01000/1", upd_valid, pend, drop_cnt);
      else pass_cnt++;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total_cnt++;
      if ({upd_valid, upd_idx, upd_dt, upd_ltp, pend, drop_cnt} !== '0)
         $display("FAIL rstmid_clear got v=%0b idx=%0d dt=%0d ltp=%0b pend=%b drop=%0d want all zero",
                  upd_valid, upd_idx, upd_dt, upd_ltp, pend, drop_cnt);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({upd_valid, pend} !== 6'b0)
         $display("FAIL rstmid_stay got v=%0b pend=%b want 0/00000", upd_valid, pend);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      do_reset();
      upd_ready = 1'b1;
      pre_spike = 5'b00010;
      step();
      pre_spike  = '0;
      post_spike = 1'b1;
      step();
      post_spike = 1'b0;
      step();
      total_cnt++;
      if ({upd_valid, upd_idx} !== {1'b1, 3'd1})
         $display("FAIL rr_first got v=%0b idx=%0d want 1/1", upd_valid, upd_idx);
      else pass_cnt++;
      step();
      repeat (20) step();
      pre_spike = 5'b01011;
      step();
      pre_spike  = '0;
      post_spike = 1'b1;
      step();
      post_spike = 1'b0;
      total_cnt++;
      if (pend !== 5'b01011)
         $display("FAIL rr_pend got pend=%b want 01011", pend);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({upd_valid, upd_idx, upd_dt, upd_ltp} !== {1'b1, 3'd3, 8'd1, 1'b1})
         $display("FAIL rr_order0 got v=%0b idx=%0d dt=%0d ltp=%0b want 1/3/1/1",
                  upd_valid, upd_idx, upd_dt, upd_ltp);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({upd_valid, upd_idx} !== {1'b1, 3'd0})
         $display("FAIL rr_order1 got v=%0b idx=%0d want 1/0", upd_valid, upd_idx);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({upd_valid, upd_idx} !== {1'b1, 3'd1})
         $display("FAIL rr_order2 got v=%0b idx=%0d want 1/1", upd_valid, upd_idx);
      else pass_cnt++;
      step();
      total_cnt++;
      if (upd_valid !== 1'b0)
         $display("FAIL rr_drain got v=%0b want 0", upd_valid);
      else pass_cnt++;
   endtask

   initial begin
      rst_n      = 1'b0;
      pre_spike  = '0;
      post_spike = 1'b0;
      upd_ready  = 1'b0;
      test_reset();
      test_post_only();
      test_ltp();
      test_ltd();
      test_back_to_back();
      test_window();
      test_overwrite();
      test_reset_mid();
      test_round_robin();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
